// File: rtl/fp_mult_seq.sv
// Sequencer for a binary32 multiply around an external mantissa multiplier datapath.
// Define FP_MULT_SEQ_FLAGS_EN to add the {invalid, overflow, underflow, inexact} flags output.
module fp_mult_seq #(
   parameter int MUL_LATENCY = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] op_a,
   input  logic [31:0] op_b,
   output logic        mul_sign_a,
   output logic        mul_sign_b,
   output logic [7:0]  mul_exp_a,
   output logic [7:0]  mul_exp_b,
   output logic [23:0] mul_mant_a,
   output logic [23:0] mul_mant_b,
   input  logic [47:0] mul_product,
   output logic        out_valid,
   input  logic        out_ready,
`ifdef FP_MULT_SEQ_FLAGS_EN
   output logic [3:0]  flags,
`endif
   output logic [31:0] result
);

   typedef enum logic [2:0] {IDLE, MUL, NORM, RND, DONE} state_t;
   typedef enum logic [1:0] {SP_NONE, SP_NAN, SP_INF, SP_ZERO} special_t;

   localparam logic [3:0] LAT = 4'(MUL_LATENCY);

   state_t          state, next_state;
   special_t        special_in, special_reg;
   logic [3:0]      wait_cnt;
   logic [31:0]     a_reg, b_reg;
   logic [47:0]     prod_reg;
   logic [22:0]     mant_reg, mant_rnd;
   logic            guard_reg, sticky_reg;
   logic signed [9:0] exp_reg, exp_sum, exp_fin;
   logic            round_up, carry, sign, ovf, unf;
   logic [31:0]     packed_res;

   logic a_max, b_max, a_nz, b_nz, a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
   assign a_max  = &op_a[30:23];
   assign b_max  = &op_b[30:23];
   assign a_nz   = |op_a[22:0];
   assign b_nz   = |op_b[22:0];
   assign a_zero = ~|op_a[30:23];
   assign b_zero = ~|op_b[30:23];
   assign a_inf  = a_max & ~a_nz;
   assign b_inf  = b_max & ~b_nz;
   assign a_nan  = a_max & a_nz;
   assign b_nan  = b_max & b_nz;

   // Special operands are classified at accept; the multiply is still sequenced so latency is fixed.
   always_comb begin
      special_in = SP_NONE;
      if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero))
         special_in = SP_NAN;
      else if (a_inf || b_inf)
         special_in = SP_INF;
      else if (a_zero || b_zero)
         special_in = SP_ZERO;
   end

`ifdef FP_MULT_SEQ_FLAGS_EN
   logic invalid_in, invalid_reg;
   assign invalid_in = (a_nan && !op_a[22]) || (b_nan && !op_b[22]) ||
                       (a_inf && b_zero) || (b_inf && a_zero);
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= next_state;
   end

   always_comb begin
      next_state = state;
      case (state)
         IDLE: if (in_valid) next_state = MUL;
         MUL:  if (wait_cnt == LAT) next_state = NORM;
         NORM: next_state = RND;
         RND:  next_state = DONE;
         DONE: if (out_ready) next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   always_comb begin
      in_ready  = (state == IDLE);
      out_valid = (state == DONE);
   end

   assign exp_sum = $signed({2'b00, a_reg[30:23]}) + $signed({2'b00, b_reg[30:23]}) - 10'sd127;
   assign sign    = a_reg[31] ^ b_reg[31];

   // Rounding and final packing; a carry out of the fraction leaves it zero and bumps the exponent.
   always_comb begin
      round_up          = guard_reg & (sticky_reg | mant_reg[0]);
      {carry, mant_rnd} = {1'b0, mant_reg} + 24'(round_up);
      exp_fin           = exp_reg + 10'(carry);
      ovf               = (exp_fin >= 10'sd255);
      unf               = (exp_fin <= 10'sd0);
      case (special_reg)
         SP_NAN:  packed_res = 32'h7FC0_0000;
         SP_INF:  packed_res = {sign, 8'hFF, 23'd0};
         SP_ZERO: packed_res = {sign, 31'd0};
         default: begin
            if (ovf)      packed_res = {sign, 8'hFF, 23'd0};
            else if (unf) packed_res = {sign, 31'd0};
            else          packed_res = {sign, exp_fin[7:0], mant_rnd};
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         a_reg       <= '0;
         b_reg       <= '0;
         special_reg <= SP_NONE;
         wait_cnt    <= '0;
         mul_sign_a  <= 1'b0;
         mul_sign_b  <= 1'b0;
         mul_exp_a   <= '0;
         mul_exp_b   <= '0;
         mul_mant_a  <= '0;
         mul_mant_b  <= '0;
         prod_reg    <= '0;
         mant_reg    <= '0;
         guard_reg   <= 1'b0;
         sticky_reg  <= 1'b0;
         exp_reg     <= '0;
         result      <= '0;
`ifdef FP_MULT_SEQ_FLAGS_EN
         invalid_reg <= 1'b0;
         flags       <= '0;
`endif
      end else begin
         case (state)
            IDLE: if (in_valid) begin
               a_reg       <= op_a;
               b_reg       <= op_b;
               special_reg <= special_in;
               wait_cnt    <= '0;
`ifdef FP_MULT_SEQ_FLAGS_EN
               invalid_reg <= invalid_in;
`endif
            end
            MUL: begin
               if (wait_cnt == 4'd0) begin
                  mul_sign_a <= a_reg[31];
                  mul_sign_b <= b_reg[31];
                  mul_exp_a  <= a_reg[30:23];
                  mul_exp_b  <= b_reg[30:23];
                  mul_mant_a <= {|a_reg[30:23], a_reg[22:0]};
                  mul_mant_b <= {|b_reg[30:23], b_reg[22:0]};
               end
               if (wait_cnt == LAT) begin
                  prod_reg <= mul_product;
                  wait_cnt <= '0;
               end else begin
                  wait_cnt <= wait_cnt + 4'd1;
               end
            end
            NORM: begin
               if (prod_reg[47]) begin
                  mant_reg   <= prod_reg[46:24];
                  guard_reg  <= prod_reg[23];
                  sticky_reg <= |prod_reg[22:0];
                  exp_reg    <= exp_sum + 10'sd1;
               end else begin
                  mant_reg   <= prod_reg[45:23];
                  guard_reg  <= prod_reg[22];
                  sticky_reg <= |prod_reg[21:0];
                  exp_reg    <= exp_sum;
               end
            end
            RND: begin
               result <= packed_res;
`ifdef FP_MULT_SEQ_FLAGS_EN
               flags  <= {invalid_reg,
                          (special_reg == SP_NONE) & ovf,
                          (special_reg == SP_NONE) & unf,
                          (special_reg == SP_NONE) & (guard_reg | sticky_reg | ovf | unf)};
`endif
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_fp_mult_seq.sv
// Directed-vector bench for fp_mult_seq, with a behavioural multiplier on mul_product.
// Flag checks are compiled in when FP_MULT_SEQ_FLAGS_EN is defined.
module tb_fp_mult_seq;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_valid = 1'b0, in_valid3 = 1'b0;
   logic        out_ready = 1'b0, out_ready3 = 1'b0;
   logic [31:0] op_a = '0, op_b = '0;
   logic        in_ready, in_ready3, out_valid, out_valid3;
   logic        sa, sb, sa3, sb3;
   logic [7:0]  ea, eb, ea3, eb3;
   logic [23:0] ma, mb, ma3, mb3;
   logic [47:0] prod, prod3;
   logic [31:0] result, result3;
`ifdef FP_MULT_SEQ_FLAGS_EN
   logic [3:0]  flags, flags3;
`endif

   int errors = 0;
   int checks = 0;
   bit busy_bad;

   always #5 clk = ~clk;

   assign prod  = {24'd0, ma} * {24'd0, mb};
   assign prod3 = {24'd0, ma3} * {24'd0, mb3};

   fp_mult_seq #(.MUL_LATENCY(1)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .op_a(op_a), .op_b(op_b),
      .mul_sign_a(sa), .mul_sign_b(sb), .mul_exp_a(ea), .mul_exp_b(eb),
      .mul_mant_a(ma), .mul_mant_b(mb), .mul_product(prod),
      .out_valid(out_valid), .out_ready(out_ready),
`ifdef FP_MULT_SEQ_FLAGS_EN
      .flags(flags),
`endif
      .result(result)
   );

   fp_mult_seq #(.MUL_LATENCY(3)) dut3 (
      .clk(clk), .rst(rst), .in_valid(in_valid3), .in_ready(in_ready3),
      .op_a(op_a), .op_b(op_b),
      .mul_sign_a(sa3), .mul_sign_b(sb3), .mul_exp_a(ea3), .mul_exp_b(eb3),
      .mul_mant_a(ma3), .mul_mant_b(mb3), .mul_product(prod3),
      .out_valid(out_valid3), .out_ready(out_ready3),
`ifdef FP_MULT_SEQ_FLAGS_EN
      .flags(flags3),
`endif
      .result(result3)
   );

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] exp_res;
      logic [3:0]  exp_flags;
   } vec_t;

   vec_t vecs[15];

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Called at a negedge; returns at the negedge where out_valid is seen (or the bound expires).
   task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b, output int lat);
      int w = 0;
      while (!in_ready && w < 20) begin
         @(negedge clk);
         w++;
      end
      op_a = a;
      op_b = b;
      in_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      busy_bad = 1'b0;
      lat = 0;
      while (!out_valid && lat < 40) begin
         if (in_ready) busy_bad = 1'b1;
         @(negedge clk);
         lat++;
      end
   endtask

   task automatic completeHandshake(input string name);
      out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      out_ready = 1'b0;
      checkOutput({name, "_ov_drop"}, {31'd0, out_valid}, 32'd0);
   endtask

   initial begin
      int lat;
      bit seen;

      vecs[0]  = '{32'h4000_0000, 32'h4040_0000, 32'h40C0_0000, 4'b0000};
      vecs[1]  = '{32'hC000_0000, 32'h4040_0000, 32'hC0C0_0000, 4'b0000};
      vecs[2]  = '{32'h3FC0_0000, 32'h3FC0_0000, 32'h4010_0000, 4'b0000};
      vecs[3]  = '{32'h3F80_0001, 32'h3F80_0001, 32'h3F80_0002, 4'b0001};
      vecs[4]  = '{32'h3FFF_FFFF, 32'h3FFF_FFFF, 32'h407F_FFFE, 4'b0001};
      vecs[5]  = '{32'h3FC0_0001, 32'h3FC0_0001, 32'h4010_0002, 4'b0001};
      vecs[6]  = '{32'h7F00_0000, 32'h7F00_0000, 32'h7F80_0000, 4'b0101};
      vecs[7]  = '{32'h7F80_0000, 32'h0000_0000, 32'h7FC0_0000, 4'b1000};
      vecs[8]  = '{32'h0000_0001, 32'h4000_0000, 32'h0000_0000, 4'b0000};
      vecs[9]  = '{32'h0080_0000, 32'h0080_0000, 32'h0000_0000, 4'b0011};
      vecs[10] = '{32'h7FC0_0000, 32'h3F80_0000, 32'h7FC0_0000, 4'b0000};
      vecs[11] = '{32'h7F80_0000, 32'hC000_0000, 32'hFF80_0000, 4'b0000};
      vecs[12] = '{32'h7FA0_0000, 32'h3F80_0000, 32'h7FC0_0000, 4'b1000};
      vecs[13] = '{32'h8000_0000, 32'h4000_0000, 32'h8000_0000, 4'b0000};
      vecs[14] = '{32'hFF00_0000, 32'h7F00_0000, 32'hFF80_0000, 4'b0101};

      repeat (2) @(negedge clk);
      checkOutput("rst_out_valid", {31'd0, out_valid}, 32'd0);
      checkOutput("rst_result", result, 32'd0);
      checkOutput("rst_mul_fields", {sa, sb, ea, eb, ma[7:0]}, 32'd0);
      checkOutput("rst_mul_mant", {8'd0, mb}, 32'd0);
      rst = 1'b0;
      @(negedge clk);
      checkOutput("rst_in_ready", {31'd0, in_ready}, 32'd1);
      checkOutput("rst_in_ready3", {31'd0, in_ready3}, 32'd1);

      for (int i = 0; i < 15; i++) begin
         applyStimulus(vecs[i].a, vecs[i].b, lat);
         checkOutput($sformatf("v%0d_latency", i), lat, 32'd4);
         checkOutput($sformatf("v%0d_result", i), result, vecs[i].exp_res);
`ifdef FP_MULT_SEQ_FLAGS_EN
         checkOutput($sformatf("v%0d_flags", i), {28'd0, flags}, {28'd0, vecs[i].exp_flags});
`endif
         checkOutput($sformatf("v%0d_mul_fields", i), {14'd0, sa, sb, ea, eb},
                     {14'd0, vecs[i].a[31], vecs[i].b[31], vecs[i].a[30:23], vecs[i].b[30:23]});
         checkOutput($sformatf("v%0d_in_ready_busy", i), {31'd0, busy_bad}, 32'd0);
         completeHandshake($sformatf("v%0d", i));
      end

      // Backpressure: result must hold and new operands must be ignored while DONE waits.
      applyStimulus(32'h4000_0000, 32'h4040_0000, lat);
      for (int k = 0; k < 3; k++) begin
         op_a = 32'h3F80_0000;
         op_b = 32'h3F80_0000;
         in_valid = 1'b1;
         @(posedge clk);
         @(negedge clk);
         checkOutput($sformatf("bp%0d_out_valid", k), {31'd0, out_valid}, 32'd1);
         checkOutput($sformatf("bp%0d_result", k), result, 32'h40C0_0000);
         checkOutput($sformatf("bp%0d_in_ready", k), {31'd0, in_ready}, 32'd0);
      end
      in_valid = 1'b0;
      completeHandshake("bp");
      checkOutput("bp_idle_in_ready", {31'd0, in_ready}, 32'd1);

      // Reset while in MUL aborts the operation with no result.
      op_a = 32'h4000_0000;
      op_b = 32'h4040_0000;
      in_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      rst = 1'b1;
      #1;
      checkOutput("rstmul_out_valid", {31'd0, out_valid}, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      checkOutput("rstmul_in_ready", {31'd0, in_ready}, 32'd1);
      seen = 1'b0;
      out_ready = 1'b1;
      repeat (8) begin
         @(negedge clk);
         if (out_valid) seen = 1'b1;
      end
      out_ready = 1'b0;
      checkOutput("rstmul_no_result", {31'd0, seen}, 32'd0);
      applyStimulus(32'h4000_0000, 32'h4040_0000, lat);
      checkOutput("post_rst_latency", lat, 32'd4);
      checkOutput("post_rst_result", result, 32'h40C0_0000);

      // Reset while DONE drops out_valid at once.
      rst = 1'b1;
      #1;
      checkOutput("rstdone_out_valid", {31'd0, out_valid}, 32'd0);
      checkOutput("rstdone_result", result, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      // MUL_LATENCY=3 instance.
      op_a = 32'h4000_0000;
      op_b = 32'h4040_0000;
      in_valid3 = 1'b1;
      @(posedge clk);
      @(negedge clk);
      in_valid3 = 1'b0;
      lat = 0;
      while (!out_valid3 && lat < 40) begin
         @(negedge clk);
         lat++;
      end
      checkOutput("l3_latency", lat, 32'd6);
      checkOutput("l3_result", result3, 32'h40C0_0000);
      checkOutput("l3_mul_fields", {14'd0, sa3, sb3, ea3, eb3}, {14'd0, 1'b0, 1'b0, 8'd128, 8'd128});
`ifdef FP_MULT_SEQ_FLAGS_EN
      checkOutput("l3_flags", {28'd0, flags3}, 32'd0);
`endif
      out_ready3 = 1'b1;
      @(posedge clk);
      @(negedge clk);
      out_ready3 = 1'b0;
      checkOutput("l3_ov_drop", {31'd0, out_valid3}, 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
